dice_roller: RTL

//  Dice stage directly downstream of the game FSM: consumes roll_trigger, dice_clear, hold_sw and the

---
 rtl/dice_pkg.sv | 27 ++
 rtl/lfsr16.sv | 24 ++
 rtl/dice_roller.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared constants, state encoding and field helper for the dice stage.
package dice_pkg;

    localparam int unsigned NUM_DICE = 5;
    localparam int unsigned DIE_W    = 3;
    localparam int unsigned DICE_W   = NUM_DICE * DIE_W;

    localparam logic [DIE_W-1:0] FACE_BLANK = '0;
    localparam logic [DIE_W-1:0] FACE_MIN   = 3'd1;
    localparam logic [DIE_W-1:0] FACE_MAX   = 3'd6;

    // Fibonacci taps 16,14,13,11 counted from the output end (bit 0): bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        SETTLE,
        DONE
    } state_t;

    // Extract the DIE_W-bit field for die idx from a packed vector.
    function automatic logic [DIE_W-1:0] die_field(input logic [15:0] vec, input int unsigned idx);
        return DIE_W'(vec >> (idx * DIE_W));
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifting toward bit 0 with feedback into bit 15.
module lfsr16
    import dice_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic fb;

    assign fb = ^(q & LFSR_TAPS);

    // Free-running shift; reloads the seed on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= seed;
        end else begin
            q <= {fb, q[15:1]};
        end
    end

endmodule

// File: rtl/dice_roller.sv
// Dice stage: rerolls non-held dice from a free-running LFSR and reports
// completion with a one-cycle roll_done pulse.
// Optional build macro DICE_ANIM_EN adds a cosmetic SPIN phase before SETTLE.
module dice_roller
    import dice_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned ANIM_CYCLES = 24,
    parameter int unsigned ANIM_STEP   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        roll_trigger,
    input  logic        dice_clear,
    input  logic [4:0]  hold_sw,
    input  logic [1:0]  roll_cnt,
    output logic [14:0] dice_vals,
    output logic [4:0]  dice_sum,
    output logic        busy,
    output logic        roll_done,
    output logic        roll_reject
);

    localparam logic [15:0] SEED_EFF = (LFSR_SEED == '0) ? 16'h0001 : LFSR_SEED;

    if (ANIM_CYCLES == 0 || ANIM_STEP == 0) begin : g_bad_anim
        $error("dice_roller: ANIM_CYCLES and ANIM_STEP must be non-zero");
    end

    logic [15:0]       lfsr;
    state_t            state_q, state_d;
    logic [DICE_W-1:0] dice_q, dice_d;
    logic [4:0]        pend_q, pend_d;
    logic [4:0]        sum_q, sum_d;
    logic              done_q, done_d;
    logic              rej_q, rej_d;
    logic [4:0]        blank;
    logic [4:0]        face_sum;

`ifdef DICE_ANIM_EN
    localparam int unsigned CNT_W = $clog2(ANIM_CYCLES + ANIM_STEP + 1);
    logic [CNT_W-1:0] spin_q, spin_d;
    logic [CNT_W-1:0] step_q, step_d;
`endif

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .seed    (SEED_EFF),
        .q       (lfsr)
    );

    // Per-die blank flags and the running face total of the current dice.
    always_comb begin
        blank    = '0;
        face_sum = '0;
        for (int unsigned i = 0; i < NUM_DICE; i++) begin
            if (die_field({1'b0, dice_q}, i) == FACE_BLANK) begin
                blank = blank | (5'd1 << i);
            end
            face_sum = face_sum + 5'(die_field({1'b0, dice_q}, i));
        end
    end

    // Next-state and datapath update; dice_clear overrides everything.
    always_comb begin
        logic [DIE_W-1:0] f;
        f       = '0;
        state_d = state_q;
        dice_d  = dice_q;
        pend_d  = pend_q;
        sum_d   = sum_q;
        done_d  = 1'b0;
        rej_d   = 1'b0;
`ifdef DICE_ANIM_EN
        spin_d  = spin_q;
        step_d  = step_q;
`endif
        if (dice_clear) begin
            state_d = IDLE;
            dice_d  = '0;
            pend_d  = '0;
            sum_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (roll_trigger) begin
                        if ((roll_cnt == 2'd0 && |hold_sw) || roll_cnt == 2'd3) begin
                            rej_d = 1'b1;
                        end else begin
                            // Blank dice are always rerolled, whatever the hold switches say.
                            pend_d = (roll_cnt == 2'd0) ? '1 : (~hold_sw | blank);
`ifdef DICE_ANIM_EN
                            state_d = SPIN;
                            spin_d  = '0;
                            step_d  = '0;
`else
                            state_d = SETTLE;
`endif
                        end
                    end
                end
`ifdef DICE_ANIM_EN
                SPIN: begin
                    if (step_q == '0) begin
                        for (int unsigned i = 0; i < NUM_DICE; i++) begin
                            if ((pend_q & (5'd1 << i)) != '0) begin
                                f = die_field(lfsr, i);
                                f = ((f >= 3'd6) ? (f - 3'd6) : f) + 3'd1;
                                dice_d = (dice_d & ~(DICE_W'(7) << (i * DIE_W)))
                                       | (DICE_W'(f) << (i * DIE_W));
                            end
                        end
                    end
                    step_d = (step_q == CNT_W'(ANIM_STEP - 1)) ? '0 : step_q + 1'b1;
                    if (spin_q == CNT_W'(ANIM_CYCLES - 1)) begin
                        state_d = SETTLE;
                    end else begin
                        spin_d = spin_q + 1'b1;
                    end
                end
`endif
                SETTLE: begin
                    for (int unsigned i = 0; i < NUM_DICE; i++) begin
                        if ((pend_q & (5'd1 << i)) != '0) begin
                            f = die_field(lfsr, i);
                            if (f >= FACE_MIN && f <= FACE_MAX) begin
                                dice_d = (dice_d & ~(DICE_W'(7) << (i * DIE_W)))
                                       | (DICE_W'(f) << (i * DIE_W));
                                pend_d = pend_d & ~(5'd1 << i);
                            end
                        end
                    end
                    if (pend_d == '0) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    sum_d   = face_sum;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dice_q  <= '0;
            pend_q  <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            rej_q   <= 1'b0;
`ifdef DICE_ANIM_EN
            spin_q  <= '0;
            step_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            dice_q  <= dice_d;
            pend_q  <= pend_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
            rej_q   <= rej_d;
`ifdef DICE_ANIM_EN
            spin_q  <= spin_d;
            step_q  <= step_d;
`endif
        end
    end

    assign dice_vals   = dice_q;
    assign dice_sum    = sum_q;
    assign busy        = (state_q != IDLE);
    assign roll_done   = done_q;
    assign roll_reject = rej_q;

endmodule
